uart_tx_scheduler: RTL and testbench

Round-robin scheduler that shares one UART transmit line between several byte producers and sequences each complete 8N1 frame: start bit, 8 data bits LSB first, optional parity bit, stop bit. It sits between the on-board clients, such as the clock display and debug logger, and the board's TX pin. It replaces the stand-alone start-bit generator as the single owner of `tx`.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_baud_tick.sv | 33 +++
 rtl/uart_tx_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: frame state encoding,
// data width and the bit-period computation.
package uart_pkg;

    localparam int unsigned DataBits = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Clock cycles per serial bit; integer division, truncating.
    function automatic int unsigned bit_cycles(input int unsigned clock_frequency,
                                               input int unsigned baud_rate);
        return clock_frequency / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter. Pulses tick on the last cycle of each bit period while
// enabled; restarts from zero on clear or reset.
module uart_baud_tick #(
    parameter int unsigned BitCycles = 104
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CntWidth = (BitCycles > 1) ? $clog2(BitCycles) : 1;
    localparam logic [CntWidth-1:0] LastCount = CntWidth'(BitCycles - 1);

    logic [CntWidth-1:0] count;

    // Count 0..BitCycles-1 and wrap at each bit boundary.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            if (count == LastCount) begin
                count <= '0;
            end else begin
                count <= count + CntWidth'(1);
            end
        end
    end

    assign tick = enable && (count == LastCount);

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one 8N1 UART transmit line between several
// byte producers. Define UART_TX_PARITY_EN to insert an even parity bit
// between the data bits and the stop bit (11-bit frames instead of 10).
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int unsigned ClockFrequency = 1000000,
    parameter int unsigned BaudRate       = 9600,
    parameter int unsigned Requesters     = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [Requesters-1:0]     request,
    input  logic [8*Requesters-1:0]   data,
    output logic [Requesters-1:0]     grant,
    output logic                      busy,
    output logic                      tx
);

    localparam int unsigned BitCycles = bit_cycles(ClockFrequency, BaudRate);
    localparam int unsigned PtrWidth  = (Requesters > 1) ? $clog2(Requesters) : 1;
    localparam int unsigned SumWidth  = PtrWidth + 1;
    localparam logic [PtrWidth-1:0] LastReset  = PtrWidth'(Requesters - 1);
    localparam logic [2:0]          BitIdxLast = 3'(DataBits - 1);

    if (BitCycles < 1) begin : g_bad_baud
        $error("uart_tx_scheduler: ClockFrequency/BaudRate must be at least 1");
    end
    if (Requesters < 1 || Requesters > 8) begin : g_bad_requesters
        $error("uart_tx_scheduler: Requesters must be in 1..8");
    end

    state_t                state_q, state_d;
    logic [PtrWidth-1:0]   last;
    logic [PtrWidth-1:0]   winner;
    logic [PtrWidth-1:0]   cand;
    logic [SumWidth-1:0]   sum;
    logic [7:0]            win_byte;
    logic                  found;
    logic                  accept;
    logic                  tick;
    logic [DataBits-1:0]   shift_reg;
    logic [2:0]            bit_idx;
    logic [7:0]            bytes [Requesters];
`ifdef UART_TX_PARITY_EN
    logic                  parity_bit;
`endif

    for (genvar g = 0; g < Requesters; g++) begin : g_bytes
        assign bytes[g] = data[8*g +: 8];
    end

    // Round-robin search from last+1, wrapping; first pending request wins.
    always_comb begin
        found    = 1'b0;
        winner   = last;
        win_byte = '0;
        sum      = '0;
        cand     = '0;
        for (int i = 1; i <= int'(Requesters); i++) begin
            sum = {1'b0, last} + SumWidth'(i);
            if (sum >= SumWidth'(Requesters)) begin
                sum = sum - SumWidth'(Requesters);
            end
            cand = sum[PtrWidth-1:0];
            if (!found && request[cand]) begin
                found    = 1'b1;
                winner   = cand;
                win_byte = bytes[cand];
            end
        end
    end

    assign accept = (state_q == IDLE) && found;

    uart_baud_tick #(
        .BitCycles (BitCycles)
    ) u_baud_tick (
        .clock  (clock),
        .reset  (reset),
        .clear  (accept),
        .enable (state_q != IDLE),
        .tick   (tick)
    );

    // Frame state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame sequencing: each non-idle state lasts until the bit-period tick.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (found) state_d = START;
            START:  if (tick) state_d = DATA;
            DATA: begin
                if (tick && bit_idx == BitIdxLast) begin
`ifdef UART_TX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (tick) state_d = STOP;
`endif
            STOP:   if (tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: accept/latch, shift register, registered line and handshake.
    always_ff @(posedge clock) begin
        if (reset) begin
            tx         <= 1'b1;
            busy       <= 1'b0;
            grant      <= '0;
            shift_reg  <= '0;
            bit_idx    <= '0;
            last       <= LastReset;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            grant <= '0;
            case (state_q)
                IDLE: begin
                    if (found) begin
                        shift_reg  <= win_byte;
                        grant      <= Requesters'(1) << winner;
                        tx         <= 1'b0;
                        busy       <= 1'b1;
                        bit_idx    <= '0;
                        last       <= winner;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^win_byte;
`endif
                    end
                end
                START: begin
                    if (tick) tx <= shift_reg[0];
                end
                DATA: begin
                    if (tick) begin
                        shift_reg <= shift_reg >> 1;
                        if (bit_idx == BitIdxLast) begin
                            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                            tx <= parity_bit;
`else
                            tx <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            // Next data bit is bit 1 before the shift lands.
                            tx      <= shift_reg[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (tick) tx <= 1'b1;
                end
`endif
                STOP: begin
                    if (tick) busy <= 1'b0;
                end
                default: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with BitCycles=10 and two producers.
// Honours UART_TX_PARITY_EN to switch between 10- and 11-bit frame expectations.
module tb_uart_tx_scheduler;

    localparam int unsigned CF = 1000000;
    localparam int unsigned BR = 100000;
    localparam int unsigned R  = 2;
    localparam int BC = 10;
`ifdef UART_TX_PARITY_EN
    localparam int FrameBits = 11;
    localparam bit ParityEn  = 1'b1;
`else
    localparam int FrameBits = 10;
    localparam bit ParityEn  = 1'b0;
`endif
    localparam int FrameCycles = FrameBits * BC;

    logic           clock = 1'b0;
    logic           reset;
    logic [R-1:0]   request;
    logic [8*R-1:0] data;
    logic [R-1:0]   grant;
    logic           busy;
    logic           tx;

    int checks   = 0;
    int failures = 0;

    uart_tx_scheduler #(
        .ClockFrequency (CF),
        .BaudRate       (BR),
        .Requesters     (R)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .request (request),
        .data    (data),
        .grant   (grant),
        .busy    (busy),
        .tx      (tx)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Expected line level for frame cycle c (cycle 0 is the one after grant).
    function automatic logic exp_tx(input logic [7:0] d, input int c);
        int b;
        b = c / BC;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (ParityEn && b == 9) return ^d;
        return 1'b1;
    endfunction

    task automatic do_reset();
        reset   = 1'b1;
        request = '0;
        data    = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        request = '0;
        data    = '0;
        step();
        step();
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || grant !== 2'b00) begin
            failures++;
            $display("FAIL reset_state: tx=%b busy=%b grant=%b required tx=1 busy=0 grant=00",
                     tx, busy, grant);
        end
        reset = 1'b0;
        step();
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_req: tx=%b busy=%b required tx=1 busy=0", tx, busy);
        end
    endtask

    task automatic test_single();
        logic [7:0] d;
        d = 8'h55;
        do_reset();
        data[7:0] = d;
        request   = 2'b01;
        step();
        checks++;
        if (grant !== 2'b01 || tx !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_accept: grant=%b tx=%b busy=%b required 01 0 1",
                     grant, tx, busy);
        end
        request = '0;
        for (int c = 1; c < FrameCycles; c++) begin
            step();
            checks++;
            if (tx !== exp_tx(d, c) || busy !== 1'b1 || grant !== 2'b00) begin
                failures++;
                $display("FAIL single_frame c=%0d: tx=%b busy=%b grant=%b required tx=%b busy=1 grant=00",
                         c, tx, busy, grant, exp_tx(d, c));
            end
        end
        step();
        checks++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            failures++;
            $display("FAIL single_end: busy=%b tx=%b required busy=0 tx=1", busy, tx);
        end
    endtask

    task automatic test_contention();
        logic [1:0] exp_g [4];
        logic [7:0] cur_b;
        int t_prev;
        int n;
        exp_g  = '{2'b01, 2'b10, 2'b01, 2'b10};
        t_prev = 0;
        n      = 0;
        cur_b  = 8'h00;
        do_reset();
        data    = {8'hB2, 8'hA1};
        request = 2'b11;
        for (int cyc = 1; cyc <= 4 * (FrameCycles + 1) + 20 && n < 4; cyc++) begin
            step();
            if (n > 0) begin
                for (int k = 0; k < 2; k++) begin
                    if (cyc == t_prev + BC * (k + 1)) begin
                        checks++;
                        if (tx !== cur_b[k]) begin
                            failures++;
                            $display("FAIL contend_data g=%0d bit=%0d: tx=%b required %b",
                                     n, k, tx, cur_b[k]);
                        end
                    end
                end
            end
            if (grant !== 2'b00) begin
                checks++;
                if (grant !== exp_g[n]) begin
                    failures++;
                    $display("FAIL contend_order g=%0d: grant=%b required %b", n, grant, exp_g[n]);
                end
                if (n > 0) begin
                    checks++;
                    if (cyc - t_prev != FrameCycles + 1) begin
                        failures++;
                        $display("FAIL contend_spacing g=%0d: gap=%0d required %0d",
                                 n, cyc - t_prev, FrameCycles + 1);
                    end
                end
                cur_b  = (exp_g[n] == 2'b01) ? 8'hA1 : 8'hB2;
                t_prev = cyc;
                n++;
            end
        end
        request = '0;
        checks++;
        if (n != 4) begin
            failures++;
            $display("FAIL contend_count: grants=%0d required 4", n);
        end
        repeat (FrameCycles + 2) step();
    endtask

    task automatic test_withdraw();
        int g1;
        g1 = 0;
        do_reset();
        data    = {8'hC3, 8'h3C};
        request = 2'b01;
        step();
        checks++;
        if (grant !== 2'b01) begin
            failures++;
            $display("FAIL withdraw_first: grant=%b required 01", grant);
        end
        request = '0;
        for (int c = 1; c <= FrameCycles + 30; c++) begin
            step();
            if (c == 20) request[1] = 1'b1;
            if (c == FrameCycles - 5) request[1] = 1'b0;
            if (grant !== 2'b00) g1++;
        end
        checks++;
        if (g1 != 0) begin
            failures++;
            $display("FAIL withdraw_grant: grants=%0d required 0", g1);
        end
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL withdraw_idle: tx=%b busy=%b required tx=1 busy=0", tx, busy);
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        data    = {8'hB2, 8'hA1};
        request = 2'b01;
        step();
        request = '0;
        for (int c = 1; c <= 35; c++) step();
        reset = 1'b1;
        step();
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || grant !== 2'b00) begin
            failures++;
            $display("FAIL midframe_reset: tx=%b busy=%b grant=%b required 1 0 00",
                     tx, busy, grant);
        end
        reset   = 1'b0;
        request = 2'b11;
        step();
        checks++;
        if (grant !== 2'b01 || tx !== 1'b0) begin
            failures++;
            $display("FAIL midframe_ptr: grant=%b tx=%b required grant=01 tx=0", grant, tx);
        end
        request = '0;
        repeat (FrameCycles + 2) step();
    endtask

    task automatic test_holdoff();
        reset     = 1'b1;
        data      = '0;
        data[7:0] = 8'h5A;
        request   = 2'b01;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (grant !== 2'b00 || busy !== 1'b0) begin
                failures++;
                $display("FAIL holdoff_reset i=%0d: grant=%b busy=%b required 00 0", i, grant, busy);
            end
        end
        reset = 1'b0;
        step();
        checks++;
        if (grant !== 2'b01 || busy !== 1'b1) begin
            failures++;
            $display("FAIL holdoff_grant: grant=%b busy=%b required 01 1", grant, busy);
        end
        request = '0;
        step();
        checks++;
        if (grant !== 2'b00) begin
            failures++;
            $display("FAIL holdoff_pulse: grant=%b required 00", grant);
        end
        repeat (FrameCycles + 2) step();
    endtask

    task automatic test_parity();
        do_reset();
        data[7:0] = 8'h07;
        request   = 2'b01;
        step();
        request = '0;
        for (int c = 1; c <= FrameCycles; c++) begin
            step();
            if (c == 85) begin
                checks++;
                if (tx !== 1'b0) begin
                    failures++;
                    $display("FAIL parity_bit7: tx=%b required 0", tx);
                end
            end
            if (c == 95) begin
                checks++;
                if (tx !== 1'b1) begin
                    failures++;
                    $display("FAIL parity_bit: tx=%b required 1", tx);
                end
            end
            if (c == FrameCycles - 1) begin
                checks++;
                if (busy !== 1'b1 || tx !== 1'b1) begin
                    failures++;
                    $display("FAIL parity_stop: busy=%b tx=%b required 1 1", busy, tx);
                end
            end
            if (c == FrameCycles) begin
                checks++;
                if (busy !== 1'b0) begin
                    failures++;
                    $display("FAIL parity_len: busy=%b required 0", busy);
                end
            end
        end
    endtask

    initial begin
        reset   = 1'b1;
        request = '0;
        data    = '0;
        test_reset();
        test_single();
        test_contention();
        test_withdraw();
        test_reset_midframe();
        test_holdoff();
        test_parity();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
